// File: rtl/sseg_codes_pkg.sv
// Shared constants for the seven-segment scan capture path: glyph codes,
// segment patterns (a..g = bit6..bit0, active low), anode slots and FSM states.
package sseg_codes_pkg;

  localparam int unsigned AN_W   = 3;
  localparam int unsigned SSEG_W = 8;
  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h12;
  localparam logic [CODE_W-1:0] CODE_DASH  = 5'h11;
  localparam logic [CODE_W-1:0] CODE_ERR   = 5'h1F;

  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_1     = 7'b1001111;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_6     = 7'b0100000;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0000100;
  localparam logic [6:0] PAT_A     = 7'b0001000;
  localparam logic [6:0] PAT_B     = 7'b1100000;
  localparam logic [6:0] PAT_C     = 7'b0110001;
  localparam logic [6:0] PAT_D     = 7'b1000010;
  localparam logic [6:0] PAT_E     = 7'b0110000;
  localparam logic [6:0] PAT_F     = 7'b0111000;
  localparam logic [6:0] PAT_10    = 7'b1000001;
  localparam logic [6:0] PAT_DASH  = 7'b1111110;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_13    = 7'b0001001;
  localparam logic [6:0] PAT_14    = 7'b1100010;
  localparam logic [6:0] PAT_15    = 7'b0011100;
  localparam logic [6:0] PAT_16    = 7'b1111001;
  localparam logic [6:0] PAT_17    = 7'b1001001;

  localparam logic [AN_W-1:0] AN_SLOT0 = 3'b110;
  localparam logic [AN_W-1:0] AN_SLOT1 = 3'b101;
  localparam logic [AN_W-1:0] AN_SLOT2 = 3'b011;

  localparam logic [1:0] ST_WAIT0 = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_WAIT2 = 2'd2;

  typedef struct packed {
    logic [AN_W-1:0]   an;
    logic [SSEG_W-1:0] sseg;
  } scan_sample_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational reverse decode of an active-low 7-segment pattern to a glyph code.
module sseg_pattern_decode
  import sseg_codes_pkg::*;
(
  input  logic [6:0]        pattern,
  output logic [CODE_W-1:0] code_c,
  output logic              err_c
);

  always_comb begin
    code_c = CODE_ERR;
    err_c  = 1'b0;
    case (pattern)
      PAT_0:     code_c = 5'h00;
      PAT_1:     code_c = 5'h01;
      PAT_2:     code_c = 5'h02;
      PAT_3:     code_c = 5'h03;
      PAT_4:     code_c = 5'h04;
      PAT_5:     code_c = 5'h05;
      PAT_6:     code_c = 5'h06;
      PAT_7:     code_c = 5'h07;
      PAT_8:     code_c = 5'h08;
      PAT_9:     code_c = 5'h09;
      PAT_A:     code_c = 5'h0A;
      PAT_B:     code_c = 5'h0B;
      PAT_C:     code_c = 5'h0C;
      PAT_D:     code_c = 5'h0D;
      PAT_E:     code_c = 5'h0E;
      PAT_F:     code_c = 5'h0F;
      PAT_10:    code_c = 5'h10;
      PAT_DASH:  code_c = CODE_DASH;
      PAT_BLANK: code_c = CODE_BLANK;
      PAT_13:    code_c = 5'h13;
      PAT_14:    code_c = 5'h14;
      PAT_15:    code_c = 5'h15;
      PAT_16:    code_c = 5'h16;
      PAT_17:    code_c = 5'h17;
      default:   err_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Monitors a 3-digit multiplexed seven-segment bus, qualifies each digit dwell,
// decodes it back to glyph codes and flags complete frames and staleness.
module sseg_scan_capture
  import sseg_codes_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AN_W-1:0]   an_in,
  input  logic [SSEG_W-1:0] sseg_in,
  output logic [CODE_W-1:0] hex2,
  output logic [CODE_W-1:0] hex1,
  output logic [CODE_W-1:0] hex0,
  output logic [2:0]        dp_out,
  output logic [2:0]        en_out,
  output logic [2:0]        code_err,
  output logic              frame_valid,
  output logic              stale
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0]     SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TO_MAX     = '1;

  scan_sample_t         samp;
  scan_sample_t         sample_c;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 same_c;
  logic                 slot_ok_c;
  logic [2:0]           slot_oh_c;
  logic                 capture_c;
  logic [CODE_W-1:0]    dec_code_c;
  logic                 dec_err_c;
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 frame_done_c;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [TIMEOUT_W-1:0] to_cnt_next_c;

  assign sample_c = {an_in, sseg_in};
  assign same_c   = (sample_c == samp);

  // Slot select from the registered anode; only a single low anode is a digit
  always_comb begin
    slot_ok_c = 1'b1;
    slot_oh_c = 3'b000;
    case (samp.an)
      AN_SLOT0: slot_oh_c = 3'b001;
      AN_SLOT1: slot_oh_c = 3'b010;
      AN_SLOT2: slot_oh_c = 3'b100;
      default:  slot_ok_c = 1'b0;
    endcase
  end

  // Fires only on the transition into saturation, so one capture per dwell
  assign capture_c = same_c && slot_ok_c && (settle_cnt == SETTLE_MAX - CNT_W'(1));

  sseg_pattern_decode u_decode (
    .pattern (samp.sseg[6:0]),
    .code_c  (dec_code_c),
    .err_c   (dec_err_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      samp       <= '0;
      settle_cnt <= '0;
    end else begin
      samp <= sample_c;
      if (!same_c)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_WAIT0;
    else       state_q <= state_d;
  end

  // Frame sequencing: slots must be captured 0, 1, 2 back to back
  always_comb begin
    state_d      = state_q;
    frame_done_c = 1'b0;
    if (capture_c) begin
      state_d = ST_WAIT0;
      if (slot_oh_c[0])
        state_d = ST_WAIT1;
      else if (slot_oh_c[1] && state_q == ST_WAIT1)
        state_d = ST_WAIT2;
      else if (slot_oh_c[2] && state_q == ST_WAIT2)
        frame_done_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex2        <= CODE_BLANK;
      hex1        <= CODE_BLANK;
      hex0        <= CODE_BLANK;
      dp_out      <= '0;
      en_out      <= '0;
      code_err    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done_c;
      if (capture_c) begin
        if (slot_oh_c[0]) hex2 <= dec_code_c;
        if (slot_oh_c[1]) hex1 <= dec_code_c;
        if (slot_oh_c[2]) hex0 <= dec_code_c;
        dp_out   <= (dp_out & ~slot_oh_c)   | (slot_oh_c & {3{~samp.sseg[7]}});
        en_out   <= (en_out & ~slot_oh_c)   | (slot_oh_c & {3{samp.sseg[6:0] != PAT_BLANK}});
        code_err <= (code_err & ~slot_oh_c) | (slot_oh_c & {3{dec_err_c}});
      end
    end
  end

  always_comb begin
    to_cnt_next_c = to_cnt;
    if (frame_valid)
      to_cnt_next_c = '0;
    else if (to_cnt != TO_MAX)
      to_cnt_next_c = to_cnt + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_next_c;
      stale  <= (to_cnt_next_c == TO_MAX);
    end
  end

endmodule
